ct_spsram_1024x64_ctrl: RTL and testbench

Initiator-side controller for the 1024x64 single-port SRAM in the IFU. After reset it clears the array to zero. It then turns a valid/ready request stream into SRAM pin activity, using active-low chip enable, global write enable and per-bit write enables. Read data returns on a valid/ready response channel through a 3-entry buffer, so full read throughput is sustained without combinational paths from rsp_rdy to the SRAM.

---
 rtl/ct_spsram_1024x64_ctrl.sv | 147 ++++++++++++++
 tb/tb_ct_spsram_1024x64_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_spsram_1024x64_ctrl.sv
// Initiator-side controller for the IFU 1024x64 single-port SRAM: zero-fill
// sweep after reset, then valid/ready requests with a 3-entry read return buffer.
module ct_spsram_1024x64_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    localparam state_t                ST_RST    = INIT_EN ? ST_INIT : ST_RUN;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST  = '1;
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt;

    logic                  r_cap;
    logic [DATA_WIDTH-1:0] r_mem [0:2];
    logic [1:0]            r_wptr;
    logic [1:0]            r_rptr;
    logic [1:0]            r_cnt;

    logic                  w_run;
    logic                  w_init_act;
    logic                  w_hs;
    logic [1:0]            w_occ;
    logic                  w_push;
    logic                  w_pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // ---------------- state machine ----------------
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_init_cnt == CNT_LAST) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RST;
        endcase
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_init_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_init_cnt <= r_init_cnt + CNT_ONE;
        end
    end

    // Gating with cpurst_b keeps every output at its reset value while reset
    // is held, even when the state register already reads RUN (INIT_EN=0).
    assign w_run      = (r_state == ST_RUN)  & cpurst_b;
    assign w_init_act = (r_state == ST_INIT) & cpurst_b;
    assign init_done  = w_run;

    // Credit: in-flight capture plus buffered entries must fit the 3-entry FIFO.
    assign w_occ   = {1'b0, r_cap} + r_cnt;
    assign req_rdy = w_run & (w_occ != 2'd3);
    assign w_hs    = req_vld & req_rdy;

    // ---------------- SRAM pins ----------------
    always_comb begin
        sram_a    = '0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_d    = '0;
        if (w_init_act) begin
            sram_a    = r_init_cnt;
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
        end else if (w_hs) begin
            sram_a    = req_addr;
            sram_cen  = 1'b0;
            sram_gwen = ~req_wr;
            sram_wen  = req_wr ? ~req_wmask : '1;
            sram_d    = req_wdata;
        end
    end

    // ---------------- read return path ----------------
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_cap <= 1'b0;
        end else begin
            r_cap <= w_hs & ~req_wr;
        end
    end

    assign w_push    = r_cap;
    assign w_pop     = rsp_vld & rsp_rdy;
    assign rsp_vld   = (r_cnt != 2'd0);
    assign rsp_rdata = r_mem[r_rptr];

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < 3; i++) r_mem[i] <= '0;
            r_wptr <= 2'd0;
            r_rptr <= 2'd0;
            r_cnt  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= sram_q;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_pop) r_rptr <= ptr_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_ct_spsram_1024x64_ctrl.sv
// Directed bench for ct_spsram_1024x64_ctrl with a behavioural SRAM model.
module tb_ct_spsram_1024x64_ctrl;

    logic        forever_cpuclk = 1'b0;
    logic        cpurst_b       = 1'b0;
    logic        req_vld        = 1'b0;
    logic        req_rdy;
    logic        req_wr         = 1'b0;
    logic [9:0]  req_addr       = '0;
    logic [63:0] req_wdata      = '0;
    logic [63:0] req_wmask      = '0;
    logic        rsp_vld;
    logic        rsp_rdy        = 1'b1;
    logic [63:0] rsp_rdata;
    logic        init_done;
    logic [9:0]  sram_a;
    logic        sram_cen;
    logic        sram_gwen;
    logic [63:0] sram_wen;
    logic [63:0] sram_d;
    logic [63:0] sram_q = '0;

    int n_pass = 0;
    int n_tot  = 0;

    ct_spsram_1024x64_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .INIT_EN(1'b1)) dut (
        .forever_cpuclk(forever_cpuclk), .cpurst_b(cpurst_b),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .init_done(init_done),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    // SRAM model: garbage contents at power-up so the zero-fill is observable
    logic [63:0] mem [0:1023];
    initial for (int i = 0; i < 1024; i++) mem[i] = 64'hBAD0_BAD0_0000_0000 | 64'(i);

    always @(posedge forever_cpuclk) begin
        if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q      <= mem[sram_a];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // advance to the drive point of the next cycle
    task automatic tick();
        @(posedge forever_cpuclk);
        #1;
    endtask

    // one request; returns at the drive point of the cycle after the handshake
    task automatic issue(input logic wr, input logic [9:0] ad,
                         input logic [63:0] wd, input logic [63:0] wm);
        int w;
        req_vld = 1'b1; req_wr = wr; req_addr = ad; req_wdata = wd; req_wmask = wm;
        #1;
        w = 0;
        while (req_rdy !== 1'b1 && w < 20) begin
            tick(); #1; w++;
        end
        chk("issue_rdy", req_rdy, 1'b1);
        tick();
        req_vld = 1'b0;
    endtask

    function automatic logic [63:0] bp_data(input int k);
        return {32'hA5A5_0000 + 32'(k), 32'h0F0F_1000 + 32'(k)};
    endfunction

    function automatic logic [63:0] st_data(input int k);
        return {32'hC0DE_0000 | 32'(k), ~(32'h0000_0100 * 32'(k + 1))};
    endfunction

    initial begin
        int bad, hs, nrsp, first, last, cyc;

        // ---- reset state ----
        tick(); tick(); #1;
        chk("rst_req_rdy", req_rdy, 1'b0);
        chk("rst_rsp_vld", rsp_vld, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 64'h0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_cen", sram_cen, 1'b1);
        chk("rst_gwen", sram_gwen, 1'b1);
        chk("rst_wen", sram_wen, '1);
        chk("rst_a", 64'(sram_a), 64'h0);
        chk("rst_d", sram_d, 64'h0);

        // ---- zero-fill sweep: cycle 0 starts right after release ----
        tick();
        cpurst_b = 1'b1;
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            #1;
            if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== 64'h0 ||
                sram_d !== 64'h0 || sram_a !== 10'(i) || req_rdy !== 1'b0 ||
                init_done !== 1'b0 || rsp_vld !== 1'b0) bad++;
            tick();
        end
        chk("sweep_bad_cycles", 64'(bad), 64'h0);
        #1;
        chk("c1024_init_done", init_done, 1'b1);
        chk("c1024_req_rdy", req_rdy, 1'b1);
        chk("c1024_cen_idle", sram_cen, 1'b1);

        // ---- read 0x3FF after sweep ----
        issue(1'b0, 10'h3FF, '0, '0);
        #1 chk("rd3ff_lat1_vld", rsp_vld, 1'b0);
        tick(); #1;
        chk("rd3ff_vld", rsp_vld, 1'b1);
        chk("rd3ff_data", rsp_rdata, 64'h0);
        tick();

        // ---- full write then read of 0x155 ----
        req_vld = 1'b1; req_wr = 1'b1; req_addr = 10'h155;
        req_wdata = 64'hDEADBEEF_CAFEF00D; req_wmask = '1;
        #1;
        chk("wr_cen", sram_cen, 1'b0);
        chk("wr_gwen", sram_gwen, 1'b0);
        chk("wr_wen", sram_wen, 64'h0);
        chk("wr_a", 64'(sram_a), 64'h155);
        chk("wr_d", sram_d, 64'hDEADBEEF_CAFEF00D);
        tick();
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 10'h155;
        #1;
        chk("rd_gwen", sram_gwen, 1'b1);
        chk("rd_wen", sram_wen, '1);
        chk("rd_rdy", req_rdy, 1'b1);
        tick();
        req_vld = 1'b0;
        #1;
        chk("idle_cen", sram_cen, 1'b1);
        chk("idle_a", 64'(sram_a), 64'h0);
        chk("rd155_lat1_vld", rsp_vld, 1'b0);
        tick(); #1;
        chk("rd155_vld", rsp_vld, 1'b1);
        chk("rd155_data", rsp_rdata, 64'hDEADBEEF_CAFEF00D);
        tick(); #1;
        chk("rd155_popped", rsp_vld, 1'b0);

        // ---- masked write ----
        tick();
        req_vld = 1'b1; req_wr = 1'b1; req_addr = 10'h155;
        req_wdata = '1; req_wmask = 64'h00000000_FFFF0000;
        #1 chk("mwr_wen", sram_wen, 64'hFFFFFFFF_0000FFFF);
        tick();
        req_vld = 1'b0;
        issue(1'b0, 10'h155, '0, '0);
        tick(); #1;
        chk("mrd_vld", rsp_vld, 1'b1);
        chk("mrd_data", rsp_rdata, 64'hDEADBEEF_FFFFF00D);
        tick();

        // zero-mask write changes nothing
        issue(1'b1, 10'h155, 64'h0, 64'h0);
        issue(1'b0, 10'h155, '0, '0);
        tick(); #1 chk("zmask_data", rsp_rdata, 64'hDEADBEEF_FFFFF00D);
        tick();

        // ---- backpressure: 4 reads with rsp_rdy low ----
        for (int k = 0; k < 4; k++) issue(1'b1, 10'h010 + 10'(k), bp_data(k), '1);
        rsp_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_vld = 1'b1; req_wr = 1'b0; req_addr = 10'h010 + 10'(k);
            #1 chk("bp_rdy_hi", req_rdy, 1'b1);
            tick();
        end
        req_addr = 10'h013;
        #1 chk("bp_rdy_lo0", req_rdy, 1'b0);
        tick(); #1 chk("bp_rdy_lo1", req_rdy, 1'b0);
        tick(); #1;
        chk("bp_rdy_lo2", req_rdy, 1'b0);
        chk("bp_head0", rsp_rdata, bp_data(0));
        tick();
        rsp_rdy = 1'b1;
        #1 chk("bp_pop0", rsp_rdata, bp_data(0));
        tick(); #1;
        chk("bp_4th_rdy", req_rdy, 1'b1);
        chk("bp_pop1", rsp_rdata, bp_data(1));
        tick();
        req_vld = 1'b0;
        #1 chk("bp_pop2", rsp_rdata, bp_data(2));
        tick(); #1;
        chk("bp_vld3", rsp_vld, 1'b1);
        chk("bp_pop3", rsp_rdata, bp_data(3));
        tick(); #1 chk("bp_empty", rsp_vld, 1'b0);
        tick();

        // ---- streaming 16 reads ----
        for (int k = 0; k < 16; k++) issue(1'b1, 10'h020 + 10'(k), st_data(k), '1);
        hs = 0; nrsp = 0; bad = 0; first = -1; last = -1;
        for (int c = 0; c < 22; c++) begin
            if (c < 16) begin
                req_vld = 1'b1; req_wr = 1'b0; req_addr = 10'h020 + 10'(c);
            end else begin
                req_vld = 1'b0;
            end
            #1;
            if (req_vld && req_rdy) hs++;
            if (rsp_vld) begin
                if (first < 0) first = c;
                last = c;
                if (rsp_rdata !== st_data(nrsp)) bad++;
                nrsp++;
            end
            tick();
        end
        chk("st_handshakes", 64'(hs), 64'd16);
        chk("st_responses", 64'(nrsp), 64'd16);
        chk("st_order_bad", 64'(bad), 64'd0);
        chk("st_first_cycle", 64'(first), 64'd2);
        chk("st_last_cycle", 64'(last), 64'd17);

        // ---- reset mid-sweep ----
        cpurst_b = 1'b0;
        tick();
        cpurst_b = 1'b1;
        for (int i = 0; i < 500; i++) tick();
        #1 chk("mid_a500", 64'(sram_a), 64'd500);
        #1 cpurst_b = 1'b0;
        #1;
        chk("mid_rst_cen", sram_cen, 1'b1);
        chk("mid_rst_gwen", sram_gwen, 1'b1);
        chk("mid_rst_wen", sram_wen, '1);
        chk("mid_rst_a", 64'(sram_a), 64'h0);
        chk("mid_rst_rdy", req_rdy, 1'b0);
        chk("mid_rst_done", init_done, 1'b0);
        tick(); tick();
        cpurst_b = 1'b1;
        #1;
        chk("restart_a0", 64'(sram_a), 64'h0);
        chk("restart_cen", sram_cen, 1'b0);
        cyc = 0;
        while (init_done !== 1'b1 && cyc < 1200) begin
            tick(); #1; cyc++;
        end
        chk("restart_cycles", 64'(cyc), 64'd1024);
        tick();
        issue(1'b0, 10'h155, '0, '0);
        tick(); #1 chk("restart_zeroed", rsp_rdata, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
